// File: rtl/led_matrix_refresh_scheduler_if.sv
// Bundles the object inputs and LED drive outputs of the refresh scheduler.
// The master side drives objects and enable; the slave side is the scheduler.
interface led_matrix_refresh_scheduler_if #(
    parameter int NOBJ = 8
) ();
    logic                EN;
    logic [NOBJ-1:0]     OBJ_VALID;
    logic [3*NOBJ-1:0]   OBJ_X;
    logic [4*NOBJ-1:0]   OBJ_Y;
    logic [2*NOBJ-1:0]   OBJ_COL;
    logic [9:0]          LEDout;
    logic                FRAME_START;
    logic [3:0]          CUR_IDX;

    modport master (
        output EN, OBJ_VALID, OBJ_X, OBJ_Y, OBJ_COL,
        input  LEDout, FRAME_START, CUR_IDX
    );

    modport slave (
        input  EN, OBJ_VALID, OBJ_X, OBJ_Y, OBJ_COL,
        output LEDout, FRAME_START, CUR_IDX
    );
endinterface

// File: rtl/led_matrix_refresh_scheduler.sv
// Time-multiplexes up to NOBJ objects onto one 10-bit LED drive word.
// Coordinates are snapshotted once per frame so a frame never tears.
module led_matrix_refresh_scheduler #(
    parameter int NOBJ  = 8,
    parameter int PRESC = 2000,
    parameter int DWELL = 1,
    parameter int BLANK = 1,
    parameter int GAP   = 4
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    led_matrix_refresh_scheduler_if.slave bus
);
    localparam int PW        = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
    localparam int SEG_MAX_A = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int SEG_MAX   = (SEG_MAX_A > GAP) ? SEG_MAX_A : GAP;
    localparam int SW        = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC);
    localparam logic [SW-1:0] DWELL_TOP = SW'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [SW-1:0] BLANK_TOP = SW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [SW-1:0] GAP_TOP   = SW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [3:0]    LAST_IDX  = 4'(NOBJ - 1);
    localparam logic          HAS_BLANK = (BLANK > 0);
    localparam logic          HAS_GAP   = (GAP > 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_SEEK  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_BLANK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]        r_state;
    logic [PW-1:0]     r_presc;
    logic [SW-1:0]     r_seg;
    logic [3:0]        r_idx;
    logic [9:0]        r_led;
    logic              r_frame_start;
    logic [NOBJ-1:0]   r_sh_valid;
    logic [3*NOBJ-1:0] r_sh_x;
    logic [4*NOBJ-1:0] r_sh_y;
    logic [2*NOBJ-1:0] r_sh_col;

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_idx_nxt;
    logic              w_tick;
    logic              w_seg_last;
    logic              w_seg_done;
    logic              w_live;
    logic              w_at_last;
    logic [2:0]        w_end_state;
    logic [2:0]        w_adv_state;
    logic [3:0]        w_adv_idx;
    logic              w_timed;

    function automatic logic slot_live(input logic [3:0]        idx,
                                       input logic [NOBJ-1:0]   valid,
                                       input logic [2*NOBJ-1:0] col);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NOBJ; i++) begin
            hit = (idx == 4'(i)) ? (valid[i] && (col[2*i +: 2] != 2'b00)) : hit;
        end
        return hit;
    endfunction

    function automatic logic [9:0] slot_word(input logic [3:0]        idx,
                                             input logic [3*NOBJ-1:0] x,
                                             input logic [4*NOBJ-1:0] y,
                                             input logic [2*NOBJ-1:0] col);
        logic [9:0] word;
        word = 10'd0;
        for (int i = 0; i < NOBJ; i++) begin
            word = (idx == 4'(i)) ? {col[2*i +: 2], 1'b0, y[4*i +: 4], x[3*i +: 3]} : word;
        end
        return word;
    endfunction

    // Tick, segment-end and slot qualification for the current clock.
    always_comb begin
        w_tick     = (r_presc == PRESC_TOP);
        w_live     = slot_live(r_idx, r_sh_valid, r_sh_col);
        w_at_last  = (r_idx == LAST_IDX);
        w_seg_last = 1'b0;
        w_timed    = 1'b0;
        case (r_state)
            S_SHOW:  begin w_seg_last = (r_seg == DWELL_TOP); w_timed = 1'b1; end
            S_BLANK: begin w_seg_last = (r_seg == BLANK_TOP); w_timed = 1'b1; end
            S_GAP:   begin w_seg_last = (r_seg == GAP_TOP);   w_timed = 1'b1; end
            default: begin w_seg_last = 1'b0;                 w_timed = 1'b0; end
        endcase
        w_seg_done = w_tick && w_seg_last;
    end

    // Where the scan goes once a slot is finished, and once the frame is finished.
    always_comb begin
        if (HAS_GAP) begin
            w_end_state = S_GAP;
        end else if (bus.EN) begin
            w_end_state = S_LATCH;
        end else begin
            w_end_state = S_IDLE;
        end
        if (w_at_last) begin
            w_adv_state = w_end_state;
            w_adv_idx   = r_idx;
        end else begin
            w_adv_state = S_SEEK;
            w_adv_idx   = r_idx + 4'd1;
        end
    end

    // Next-state and next-slot selection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.EN) w_state_nxt = S_LATCH;
                else        w_state_nxt = S_IDLE;
            end
            S_LATCH: begin
                w_state_nxt = S_SEEK;
            end
            S_SEEK: begin
                if (w_live) begin
                    w_state_nxt = S_SHOW;
                end else begin
                    w_state_nxt = w_adv_state;
                    w_idx_nxt   = w_adv_idx;
                end
            end
            S_SHOW: begin
                if (w_seg_done && HAS_BLANK) begin
                    w_state_nxt = S_BLANK;
                end else if (w_seg_done) begin
                    w_state_nxt = w_adv_state;
                    w_idx_nxt   = w_adv_idx;
                end else begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_BLANK: begin
                if (w_seg_done) begin
                    w_state_nxt = w_adv_state;
                    w_idx_nxt   = w_adv_idx;
                end else begin
                    w_state_nxt = S_BLANK;
                end
            end
            S_GAP: begin
                if (w_seg_done && bus.EN) w_state_nxt = S_LATCH;
                else if (w_seg_done)      w_state_nxt = S_IDLE;
                else                      w_state_nxt = S_GAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt == S_LATCH) begin
            w_idx_nxt = 4'd0;
        end else begin
            w_idx_nxt = w_idx_nxt;
        end
    end

    // State, slot index and registered drive outputs; LED word is set on SHOW entry.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_led         <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_led         <= (w_state_nxt == S_SHOW) ? slot_word(w_idx_nxt, r_sh_x, r_sh_y, r_sh_col)
                                                     : 10'd0;
            r_frame_start <= (w_state_nxt == S_LATCH);
        end
    end

    // Prescaler and segment counter restart on every state change.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_presc <= {PW{1'b0}};
            r_seg   <= {SW{1'b0}};
        end else if (w_state_nxt != r_state) begin
            r_presc <= {PW{1'b0}};
            r_seg   <= {SW{1'b0}};
        end else if (w_tick) begin
            r_presc <= {PW{1'b0}};
            r_seg   <= w_timed ? r_seg + SW'(1) : r_seg;
        end else begin
            r_presc <= r_presc + PW'(1);
            r_seg   <= r_seg;
        end
    end

    // Per-frame snapshot of the object table, taken only in LATCH.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sh_valid <= {NOBJ{1'b0}};
            r_sh_x     <= {(3*NOBJ){1'b0}};
            r_sh_y     <= {(4*NOBJ){1'b0}};
            r_sh_col   <= {(2*NOBJ){1'b0}};
        end else if (r_state == S_LATCH) begin
            r_sh_valid <= bus.OBJ_VALID;
            r_sh_x     <= bus.OBJ_X;
            r_sh_y     <= bus.OBJ_Y;
            r_sh_col   <= bus.OBJ_COL;
        end else begin
            r_sh_valid <= r_sh_valid;
            r_sh_x     <= r_sh_x;
            r_sh_y     <= r_sh_y;
            r_sh_col   <= r_sh_col;
        end
    end

    assign bus.LEDout      = r_led;
    assign bus.FRAME_START = r_frame_start;
    assign bus.CUR_IDX     = r_idx;
endmodule

// File: tb/tb_led_matrix_refresh_scheduler.sv
// Directed and randomized frames checked clock-by-clock against a frame-level model.
module tb_led_matrix_refresh_scheduler;
    localparam int N  = 4;
    localparam int P  = 3;
    localparam int DW = 2;
    localparam int BL = 1;
    localparam int GP = 2;
    localparam int T  = P + 1;

    logic clk;
    logic rst_n;
    logic rst_b_n;

    led_matrix_refresh_scheduler_if #(.NOBJ(N)) bus_a ();
    led_matrix_refresh_scheduler_if #(.NOBJ(8)) bus_b ();

    led_matrix_refresh_scheduler #(.NOBJ(N), .PRESC(P), .DWELL(DW), .BLANK(BL), .GAP(GP)) dut_a (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus_a)
    );

    led_matrix_refresh_scheduler dut_b (
        .CLK  (clk),
        .RSTn (rst_b_n),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic       tv [N];
    logic [2:0] tx [N];
    logic [3:0] ty [N];
    logic [1:0] tc [N];

    logic [9:0] q_led [$];
    logic       q_fs  [$];
    logic [3:0] q_idx [$];

    logic [9:0] watch_word;
    logic [9:0] watch2_word;
    int         watch_cnt;
    int         watch_last;
    int         watch2_first;
    int         s1_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a();
        for (int i = 0; i < N; i++) begin
            bus_a.OBJ_VALID[i]      = tv[i];
            bus_a.OBJ_X[3*i +: 3]   = tx[i];
            bus_a.OBJ_Y[4*i +: 4]   = ty[i];
            bus_a.OBJ_COL[2*i +: 2] = tc[i];
        end
    endtask

    function automatic void push(input logic [9:0] led, input logic fs, input logic [3:0] idx);
        q_led.push_back(led);
        q_fs.push_back(fs);
        q_idx.push_back(idx);
    endfunction

    // One frame, starting at the LATCH clock; act 1 moves slot 0 to row 12, act 2 drops EN.
    task automatic play_frame(input int act, input int act_at);
        logic [9:0] w;
        q_led.delete(); q_fs.delete(); q_idx.delete();
        push(10'd0, 1'b1, 4'd0);
        for (int i = 0; i < N; i++) begin
            push(10'd0, 1'b0, 4'(i));
            if (tv[i] && tc[i] != 2'b00) begin
                w = {tc[i], 1'b0, ty[i], tx[i]};
                for (int k = 0; k < DW * T; k++) push(w, 1'b0, 4'(i));
                for (int k = 0; k < BL * T; k++) push(10'd0, 1'b0, 4'(i));
            end
        end
        for (int k = 0; k < GP * T; k++) push(10'd0, 1'b0, 4'(N - 1));
        watch_cnt = 0; watch_last = -1; watch2_first = -1; s1_cnt = 0;
        for (int k = 0; k < q_led.size(); k++) begin
            @(negedge clk);
            chk("led", 32'(bus_a.LEDout), 32'(q_led[k]));
            chk("frame_start", 32'(bus_a.FRAME_START), 32'(q_fs[k]));
            chk("cur_idx", 32'(bus_a.CUR_IDX), 32'(q_idx[k]));
            if (bus_a.LEDout == watch_word) begin
                watch_cnt++;
                watch_last = k;
            end
            if (bus_a.LEDout == watch2_word && watch2_first < 0) watch2_first = k;
            if (bus_a.CUR_IDX == 4'd1 && bus_a.LEDout != 10'd0) s1_cnt++;
            if (k == act_at && act == 1) begin
                ty[0] = 4'd12;
                drive_a();
            end
            if (k == act_at && act == 2) bus_a.EN = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.EN = 1'b1;
        bus_b.EN = 1'b1;
        bus_b.OBJ_VALID = 8'b0000_0001;
        bus_b.OBJ_X = 24'd5;
        bus_b.OBJ_Y = 32'd9;
        bus_b.OBJ_COL = 16'd3;
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0; tx[i] = 3'd0; ty[i] = 4'd0; tc[i] = 2'd0;
        end
        tv[0] = 1'b1; tx[0] = 3'd1; ty[0] = 4'd13; tc[0] = 2'b10;
        drive_a();
        watch_word = 10'b1001101001;
        watch2_word = 10'h3ff;

        // Case 1: outputs dark under reset
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(bus_a.LEDout), 32'd0);
        chk("rst_fs", 32'(bus_a.FRAME_START), 32'd0);
        chk("rst_idx", 32'(bus_a.CUR_IDX), 32'd0);
        rst_n = 1'b1;

        // Case 2: single object, two frames back to back
        play_frame(0, -1);
        chk("c2_word_clocks", 32'(watch_cnt), 32'd8);
        play_frame(0, -1);
        chk("c2_word_clocks_f2", 32'(watch_cnt), 32'd8);

        // Case 3: slot 1 valid but colourless is skipped
        tv[0] = 1'b1; tx[0] = 3'd2; ty[0] = 4'd5;  tc[0] = 2'b01;
        tv[1] = 1'b1; tx[1] = 3'd6; ty[1] = 4'd3;  tc[1] = 2'b00;
        tv[2] = 1'b1; tx[2] = 3'd7; ty[2] = 4'd15; tc[2] = 2'b11;
        tv[3] = 1'b0; tx[3] = 3'd4; ty[3] = 4'd4;  tc[3] = 2'b11;
        drive_a();
        watch_word = 10'b0100101010;
        watch2_word = 10'b1101111111;
        play_frame(0, -1);
        chk("c3_slot1_driven", 32'(s1_cnt), 32'd0);
        chk("c3_slot2_delay", 32'(watch2_first - watch_last), 32'd7);

        // Case 4: row change mid-frame only lands after the next FRAME_START
        tv[0] = 1'b1; tx[0] = 3'd1; ty[0] = 4'd13; tc[0] = 2'b10;
        tv[1] = 1'b0;
        tv[2] = 1'b1; tx[2] = 3'd3; ty[2] = 4'd6;  tc[2] = 2'b01;
        drive_a();
        watch_word = 10'b1001100001;
        watch2_word = 10'h3ff;
        play_frame(1, 4);
        chk("c4_new_word_early", 32'(watch_cnt), 32'd0);
        play_frame(0, -1);
        chk("c4_new_word_next", 32'(watch_cnt), 32'd8);

        // Case 5: EN dropped mid-frame, frame completes then idles
        play_frame(2, 4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("c5_idle_led", 32'(bus_a.LEDout), 32'd0);
            chk("c5_idle_fs", 32'(bus_a.FRAME_START), 32'd0);
        end
        bus_a.EN = 1'b1;
        play_frame(0, -1);

        // Randomized object tables
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                tv[i] = 1'($urandom_range(0, 1));
                tx[i] = 3'($urandom);
                ty[i] = 4'($urandom);
                tc[i] = 2'($urandom);
            end
            drive_a();
            play_frame(0, -1);
        end

        // Case 6: default parameters, asynchronous reset during SHOW
        @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("c6_fs", 32'(bus_b.FRAME_START), 32'd1);
        @(negedge clk);
        chk("c6_seek_led", 32'(bus_b.LEDout), 32'd0);
        @(negedge clk);
        chk("c6_show_led", 32'(bus_b.LEDout), 32'(10'b1101001101));
        repeat (100) @(negedge clk);
        chk("c6_show_hold", 32'(bus_b.LEDout), 32'(10'b1101001101));
        #2 rst_b_n = 1'b0;
        #1;
        chk("c6_async_led", 32'(bus_b.LEDout), 32'd0);
        chk("c6_async_fs", 32'(bus_b.FRAME_START), 32'd0);
        chk("c6_async_idx", 32'(bus_b.CUR_IDX), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("c6_restart_fs", 32'(bus_b.FRAME_START), 32'd1);
        @(negedge clk);
        chk("c6_restart_seek", 32'(bus_b.LEDout), 32'd0);
        @(negedge clk);
        chk("c6_restart_show", 32'(bus_b.LEDout), 32'(10'b1101001101));
        chk("c6_restart_idx", 32'(bus_b.CUR_IDX), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
